// File: rtl/control_drawrect_pkg.sv
// control_drawrect_pkg
// Shared types and constants for the rectangle draw command engine.
//   drawrect_mode_e  : drawing modes carried in the first command byte
//   drawrect_state_e : command FSM states (capture, start, run, finish)
//   MODE_MAX         : highest legal mode value; anything above is malformed
//   *_BYTES          : byte counts of the fixed-size command fields
//   col_bytes()      : bytes needed to carry a column coordinate
package control_drawrect_pkg;

  typedef enum logic [7:0] {
    MODE_FILL    = 8'd0,
    MODE_OUTLINE = 8'd1
  } drawrect_mode_e;

  localparam logic [7:0] MODE_MAX = MODE_OUTLINE;

  typedef enum logic [3:0] {
    CAPTURE_MODE,
    CAPTURE_X1,
    CAPTURE_Y1,
    CAPTURE_W,
    CAPTURE_H,
    CAPTURE_COLOR,
    START,
    RUN,
    FINISH
  } drawrect_state_e;

  // Fixed-size fields; x1/width and colour sizes follow the module parameters.
  localparam int MODE_BYTES = 1;
  localparam int Y1_BYTES   = 1;
  localparam int H_BYTES    = 1;

  function automatic int col_bytes(input int pixel_width);
    return ($clog2(pixel_width) + 7) / 8;
  endfunction

endpackage

// File: rtl/control_subcmd_rectwalk.sv
// control_subcmd_rectwalk
// Walks a clipped rectangle in row-major order and issues one framebuffer
// byte write per colour byte, under a valid/ready style handshake.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start_i              : one-cycle pulse; loads the first pixel and raises the write request
//   mem_ready_i          : framebuffer accepts the current write
//   outline_i            : 1 = outline mode, 0 = fill mode
//   x_first_i, y_first_i : rectangle origin (x1, y1)
//   x_end_i, y_end_i     : exclusive clipped bounds
//   x_last_i, y_last_i   : unclipped far edges (x1+width-1, y1+height-1)
//   colour_i             : pixel colour, byte BYTES_PER_PIXEL-1 sent first
//   row_o, column_o, pixel_o, data_out_o : current write address and byte
//   ram_write_enable_o   : write request, held high until the last byte is accepted
//   last_accepted_o      : final byte of the rectangle is being accepted this cycle
module control_subcmd_rectwalk #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int COL_BITS        = $clog2(PIXEL_WIDTH),
  parameter int ROW_BITS        = $clog2(PIXEL_HEIGHT),
  parameter int PSEL_BITS       = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  parameter int XW              = 9,
  parameter int YW              = 9
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic                           mem_ready_i,
  input  logic                           outline_i,
  input  logic [XW-1:0]                  x_first_i,
  input  logic [XW-1:0]                  x_end_i,
  input  logic [XW-1:0]                  x_last_i,
  input  logic [YW-1:0]                  y_first_i,
  input  logic [YW-1:0]                  y_end_i,
  input  logic [YW-1:0]                  y_last_i,
  input  logic [8*BYTES_PER_PIXEL-1:0]   colour_i,
  output logic [ROW_BITS-1:0]            row_o,
  output logic [COL_BITS-1:0]            column_o,
  output logic [PSEL_BITS-1:0]           pixel_o,
  output logic [7:0]                     data_out_o,
  output logic                           ram_write_enable_o,
  output logic                           last_accepted_o
);

  localparam logic [PSEL_BITS-1:0] PIX_FIRST = PSEL_BITS'(BYTES_PER_PIXEL - 1);

  logic [ROW_BITS-1:0]  row_q;
  logic [COL_BITS-1:0]  col_q;
  logic [PSEL_BITS-1:0] pixel_q;
  logic [7:0]           data_q;
  logic                 we_q;

  logic                 accept;
  logic                 full_row;
  logic                 row_end;
  logic                 last_row;
  logic [XW-1:0]        col_ext;
  logic [XW-1:0]        col_next;
  logic [YW-1:0]        row_ext;
  logic [PSEL_BITS-1:0] pix_next;
  logic [7:0]           byte_next;
  logic [7:0]           byte_first;

  always_comb begin
    col_ext    = XW'(col_q);
    row_ext    = YW'(row_q);
    accept     = we_q & mem_ready_i;
    // Outline interior rows only touch the two side edges; first/last rows
    // and fill mode cover every column up to the clipped bound.
    full_row   = !outline_i || (row_ext == y_first_i) || (row_ext == y_last_i);
    col_next   = col_ext + XW'(1);
    row_end    = 1'b0;
    if (full_row) begin
      row_end = (col_next == x_end_i);
    end else if ((col_ext == x_first_i) && (x_last_i < XW'(PIXEL_WIDTH))
                 && (x_last_i != x_first_i)) begin
      // Jump straight from the left edge to the right edge, no idle cycles.
      col_next = x_last_i;
    end else begin
      row_end = 1'b1;
    end
    last_row        = ((row_ext + YW'(1)) == y_end_i);
    last_accepted_o = accept && (pixel_q == '0) && row_end && last_row;

    pix_next   = (pixel_q == '0) ? PIX_FIRST : (pixel_q - PSEL_BITS'(1));
    byte_next  = colour_i[8*int'(pix_next) +: 8];
    byte_first = colour_i[8*(BYTES_PER_PIXEL-1) +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      pixel_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else if (start_i) begin
      row_q   <= ROW_BITS'(y_first_i);
      col_q   <= COL_BITS'(x_first_i);
      pixel_q <= PIX_FIRST;
      data_q  <= byte_first;
      we_q    <= 1'b1;
    end else if (accept) begin
      // Address and data only move on an accepted write, so they hold
      // stable for as long as the framebuffer stalls.
      pixel_q <= pix_next;
      data_q  <= byte_next;
      if (pixel_q == '0) begin
        if (!row_end) begin
          col_q <= COL_BITS'(col_next);
        end else if (!last_row) begin
          row_q <= row_q + ROW_BITS'(1);
          col_q <= COL_BITS'(x_first_i);
        end else begin
          we_q  <= 1'b0;
        end
      end
    end
  end

  assign row_o              = row_q;
  assign column_o           = col_q;
  assign pixel_o            = pixel_q;
  assign data_out_o         = data_q;
  assign ram_write_enable_o = we_q;

endmodule

// File: rtl/control_cmd_drawrect.sv
// control_cmd_drawrect
// Rectangle command engine for the LED panel framebuffer. Parses a byte
// stream (mode, x1, y1, width, height, colour), clips the rectangle to the
// panel and drives the framebuffer write port through the rectangle walker.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable, data_in   : command byte and its valid, taken while ready_for_data=1
//   mem_ready         : framebuffer accepts a write this cycle
//   ready_for_data    : block accepts command bytes
//   row, column       : write address
//   pixel, data_out   : colour-byte select and colour byte
//   ram_write_enable  : write request
//   done              : one-cycle pulse at command completion
//   error             : one-cycle pulse with done for a malformed mode
module control_cmd_drawrect
  import control_drawrect_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int COL_BITS        = $clog2(PIXEL_WIDTH),
  parameter int ROW_BITS        = $clog2(PIXEL_HEIGHT),
  parameter int PSEL_BITS       = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  parameter int COL_BYTES       = col_bytes(PIXEL_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           data_in,
  input  logic                 mem_ready,
  output logic                 ready_for_data,
  output logic [ROW_BITS-1:0]  row,
  output logic [COL_BITS-1:0]  column,
  output logic [PSEL_BITS-1:0] pixel,
  output logic [7:0]           data_out,
  output logic                 ram_write_enable,
  output logic                 done,
  output logic                 error
);

  localparam int XFW = 8 * COL_BYTES;  // transmitted x1/width field width
  localparam int XW  = XFW + 1;        // one extra bit so x1+width cannot wrap
  localparam int YW  = 9;

  drawrect_state_e              state_q;
  logic [7:0]                   mode_q;
  logic [XFW-1:0]               x1_q;
  logic [7:0]                   y1_q;
  logic [XFW-1:0]               w_q;
  logic [7:0]                   h_q;
  logic [8*BYTES_PER_PIXEL-1:0] colour_q;
  logic [7:0]                   byte_cnt_q;
  logic                         ready_q;
  logic                         done_q;
  logic                         error_q;

  logic                         take;
  int                           field_len;
  logic                         field_last;
  drawrect_state_e              next_capture;
  logic [XW-1:0]                x_sum, x_end, x_last;
  logic [YW-1:0]                y_sum, y_end, y_last;
  logic                         area_empty;
  logic                         mode_bad;
  logic                         is_outline;
  logic                         walk_start;
  logic                         last_accepted;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    field_len    = 1;
    next_capture = CAPTURE_MODE;
    case (state_q)
      CAPTURE_MODE:  begin field_len = MODE_BYTES;      next_capture = CAPTURE_X1;    end
      CAPTURE_X1:    begin field_len = COL_BYTES;       next_capture = CAPTURE_Y1;    end
      CAPTURE_Y1:    begin field_len = Y1_BYTES;        next_capture = CAPTURE_W;     end
      CAPTURE_W:     begin field_len = COL_BYTES;       next_capture = CAPTURE_H;     end
      CAPTURE_H:     begin field_len = H_BYTES;         next_capture = CAPTURE_COLOR; end
      CAPTURE_COLOR: begin field_len = BYTES_PER_PIXEL; next_capture = START;         end
      default: ;
    endcase
    field_last = (byte_cnt_q == 8'(field_len - 1));
    take       = ready_q & enable;

    // Clipped bounds are derived from the captured fields, which stay
    // frozen from START until FINISH clears them.
    x_sum      = XW'(x1_q) + XW'(w_q);
    y_sum      = YW'(y1_q) + YW'(h_q);
    x_end      = (x_sum > XW'(PIXEL_WIDTH))  ? XW'(PIXEL_WIDTH)  : x_sum;
    y_end      = (y_sum > YW'(PIXEL_HEIGHT)) ? YW'(PIXEL_HEIGHT) : y_sum;
    x_last     = x_sum - XW'(1);
    y_last     = y_sum - YW'(1);
    area_empty = (w_q == '0) || (h_q == '0)
              || (XW'(x1_q) >= XW'(PIXEL_WIDTH))
              || (YW'(y1_q) >= YW'(PIXEL_HEIGHT));
    mode_bad   = (mode_q > MODE_MAX);
    is_outline = (mode_q == MODE_OUTLINE);
    walk_start = (state_q == START) && !mode_bad && !area_empty;
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CAPTURE_MODE;
      mode_q     <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      colour_q   <= '0;
      byte_cnt_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        START: begin
          if (mode_bad || area_empty) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            error_q <= mode_bad;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (last_accepted) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q    <= CAPTURE_MODE;
          ready_q    <= 1'b1;
          mode_q     <= '0;
          x1_q       <= '0;
          y1_q       <= '0;
          w_q        <= '0;
          h_q        <= '0;
          colour_q   <= '0;
          byte_cnt_q <= '0;
        end
        default: begin
          // Capture states: multi-byte fields shift in MSB first.
          if (take) begin
            case (state_q)
              CAPTURE_MODE:  mode_q   <= data_in;
              CAPTURE_X1:    x1_q     <= XFW'({x1_q, data_in});
              CAPTURE_Y1:    y1_q     <= data_in;
              CAPTURE_W:     w_q      <= XFW'({w_q, data_in});
              CAPTURE_H:     h_q      <= data_in;
              CAPTURE_COLOR: colour_q <= (8*BYTES_PER_PIXEL)'({colour_q, data_in});
              default: ;
            endcase
            if (field_last) begin
              byte_cnt_q <= '0;
              state_q    <= next_capture;
              if (state_q == CAPTURE_COLOR) ready_q <= 1'b0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  control_subcmd_rectwalk #(
    .PIXEL_WIDTH     (PIXEL_WIDTH),
    .PIXEL_HEIGHT    (PIXEL_HEIGHT),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
    .COL_BITS        (COL_BITS),
    .ROW_BITS        (ROW_BITS),
    .PSEL_BITS       (PSEL_BITS),
    .XW              (XW),
    .YW              (YW)
  ) u_walk (
    .clk                (clk),
    .reset              (reset),
    .start_i            (walk_start),
    .mem_ready_i        (mem_ready),
    .outline_i          (is_outline),
    .x_first_i          (XW'(x1_q)),
    .x_end_i            (x_end),
    .x_last_i           (x_last),
    .y_first_i          (YW'(y1_q)),
    .y_end_i            (y_end),
    .y_last_i           (y_last),
    .colour_i           (colour_q),
    .row_o              (row),
    .column_o           (column),
    .pixel_o            (pixel),
    .data_out_o         (data_out),
    .ram_write_enable_o (ram_write_enable),
    .last_accepted_o    (last_accepted)
  );

  assign ready_for_data = ready_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_control_cmd_drawrect.sv
// Directed bench for control_cmd_drawrect (64x32 panel, 2 bytes per pixel).
module tb_control_cmd_drawrect;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic       mem_ready;
  logic       ready_for_data;
  logic [4:0] row;
  logic [5:0] column;
  logic [0:0] pixel;
  logic [7:0] data_out;
  logic       ram_write_enable;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wq[$];     // accepted writes {row, column, pixel, data}
  logic [31:0] exp_q[$];  // hand-written expected writes
  int first_we, last_wr, done_at, err_seen, hold_bad, stall_seen, rdy_at1, stray;

  always #5 clk = ~clk;

  control_cmd_drawrect #(
    .PIXEL_WIDTH     (64),
    .PIXEL_HEIGHT    (32),
    .BYTES_PER_PIXEL (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .data_in          (data_in),
    .mem_ready        (mem_ready),
    .ready_for_data   (ready_for_data),
    .row              (row),
    .column           (column),
    .pixel            (pixel),
    .data_out         (data_out),
    .ram_write_enable (ram_write_enable),
    .done             (done),
    .error            (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one complete command; starts and ends on a falling edge.
  task automatic send_cmd(input logic [7:0] m, x, y, w, h, input logic [15:0] colour);
    logic [7:0] b [7];
    b = '{m, x, y, w, h, colour[15:8], colour[7:0]};
    for (int i = 0; i < 7; i++) begin
      enable  = 1'b1;
      data_in = b[i];
      @(negedge clk);
    end
    enable  = 1'b0;
    data_in = 8'h00;
  endtask

  // Observes the command after its last byte; k=1 is the START cycle.
  // After the stall_at-th accepted write, mem_ready is held low for stall_len cycles.
  task automatic run(input int stall_at, input int stall_len, input int budget);
    int          stall_left;
    logic [31:0] held;
    logic [31:0] cur;
    stall_left = 0;
    held       = '0;
    wq.delete();
    first_we = -1; last_wr = -1; done_at = -1; err_seen = 0;
    hold_bad = 0; stall_seen = 0; rdy_at1 = 1;
    for (int k = 1; k <= budget; k++) begin
      mem_ready = (stall_left == 0);
      cur = {8'(row), 8'(column), 8'(pixel), data_out};
      if (k == 1) rdy_at1 = int'(ready_for_data);
      if (ram_write_enable && first_we < 0) first_we = k;
      if (!mem_ready) begin
        if (ram_write_enable) stall_seen++;
        if (stall_left == stall_len) held = cur;
        else if (cur !== held) hold_bad++;
        stall_left--;
      end else if (ram_write_enable) begin
        wq.push_back(cur);
        last_wr = k;
        if (stall_len > 0 && wq.size() == stall_at) stall_left = stall_len;
      end
      if (done) begin
        done_at  = k;
        err_seen = int'(error);
        break;
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic add_px(input logic [7:0] r, input logic [7:0] c, input logic [15:0] colour);
    exp_q.push_back({r, c, 8'h01, colour[15:8]});
    exp_q.push_back({r, c, 8'h00, colour[7:0]});
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < wq.size()) ? wq[i] : 32'hDEAD_DEAD, exp_q[i]);
  endtask

  // One cycle after done: pulse gone, block ready for the next command.
  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_ready_back"}, ready_for_data, 1'b1);
  endtask

  task automatic expect_fill_1(input string tag);
    exp_q.delete();
    exp_q = {32'h03_02_01_AB, 32'h03_02_00_CD, 32'h03_03_01_AB, 32'h03_03_00_CD,
             32'h04_02_01_AB, 32'h04_02_00_CD, 32'h04_03_01_AB, 32'h04_03_00_CD};
    compare_writes(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; data_in = 8'h00; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_for_data, 1'b1);
    check("rst_we",    ram_write_enable, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr",  {row, column, pixel, data_out}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Fill 2x2 at (2,3), colour ABCD.
    send_cmd(8'h00, 8'h02, 8'h03, 8'h02, 8'h02, 16'hABCD);
    run(0, 0, 200);
    expect_fill_1("fill");
    check("fill_ready_low", rdy_at1, 0);
    check("fill_first_we",  first_we, 2);
    check("fill_last_wr",   last_wr, 9);
    check("fill_done_at",   done_at, 10);
    check("fill_error",     err_seen, 0);
    after_done("fill");

    // Same fill with 5 stall cycles after the third write.
    send_cmd(8'h00, 8'h02, 8'h03, 8'h02, 8'h02, 16'hABCD);
    run(3, 5, 200);
    expect_fill_1("bp");
    check("bp_hold_stable", hold_bad, 0);
    check("bp_we_in_stall", stall_seen, 5);
    check("bp_done_at",     done_at, 15);
    after_done("bp");

    // Outline 4x3 at origin: row 1 only columns 0 and 3.
    send_cmd(8'h01, 8'h00, 8'h00, 8'h04, 8'h03, 16'h1234);
    run(0, 0, 200);
    exp_q.delete();
    for (int c = 0; c < 4; c++) add_px(8'd0, 8'(c), 16'h1234);
    add_px(8'd1, 8'd0, 16'h1234);
    add_px(8'd1, 8'd3, 16'h1234);
    for (int c = 0; c < 4; c++) add_px(8'd2, 8'(c), 16'h1234);
    compare_writes("outline");
    check("outline_done_at", done_at, 22);
    check("outline_error",   err_seen, 0);
    after_done("outline");

    // Fill clipped at the right edge: columns 62, 63 only.
    send_cmd(8'h00, 8'h3E, 8'h00, 8'h04, 8'h01, 16'hBEEF);
    run(0, 0, 200);
    exp_q.delete();
    exp_q = {32'h00_3E_01_BE, 32'h00_3E_00_EF, 32'h00_3F_01_BE, 32'h00_3F_00_EF};
    compare_writes("clip_r");
    check("clip_r_done_at", done_at, 6);
    after_done("clip_r");

    // Outline whose right edge (x=65) is off panel: left edge only on row 1.
    send_cmd(8'h01, 8'h3E, 8'h00, 8'h04, 8'h03, 16'h0F0F);
    run(0, 0, 200);
    exp_q.delete();
    add_px(8'd0, 8'd62, 16'h0F0F);
    add_px(8'd0, 8'd63, 16'h0F0F);
    add_px(8'd1, 8'd62, 16'h0F0F);
    add_px(8'd2, 8'd62, 16'h0F0F);
    add_px(8'd2, 8'd63, 16'h0F0F);
    compare_writes("outl_clip");
    check("outl_clip_done_at", done_at, 12);
    after_done("outl_clip");

    // Outline of width 1 degenerates to a single column, no duplicates.
    send_cmd(8'h01, 8'h05, 8'h01, 8'h01, 8'h03, 16'h7788);
    run(0, 0, 200);
    exp_q.delete();
    for (int r = 1; r < 4; r++) add_px(8'(r), 8'd5, 16'h7788);
    compare_writes("outl_w1");
    check("outl_w1_done_at", done_at, 8);
    after_done("outl_w1");

    // Off panel (y1=40): no writes, done two cycles after the last byte.
    send_cmd(8'h00, 8'h00, 8'h28, 8'h04, 8'h04, 16'hAAAA);
    run(0, 0, 50);
    exp_q.delete();
    compare_writes("off_y");
    check("off_y_no_we",   first_we, -1);
    check("off_y_done_at", done_at, 2);
    check("off_y_error",   err_seen, 0);
    after_done("off_y");

    // Zero width: no writes.
    send_cmd(8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 16'hAAAA);
    run(0, 0, 50);
    check("w0_no_we",   first_we, -1);
    check("w0_done_at", done_at, 2);
    after_done("w0");

    // Invalid mode: done and error together, no writes.
    send_cmd(8'h07, 8'h01, 8'h01, 8'h02, 8'h02, 16'h1111);
    run(0, 0, 50);
    check("badmode_no_we",   first_we, -1);
    check("badmode_done_at", done_at, 2);
    check("badmode_error",   err_seen, 1);
    after_done("badmode");

    // Reset in the middle of a 10x10 fill.
    send_cmd(8'h00, 8'h00, 8'h00, 8'h0A, 8'h0A, 16'h5555);
    repeat (4) @(negedge clk);
    check("midrun_we_high", ram_write_enable, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_we",    ram_write_enable, 1'b0);
    check("midrun_rst_ready", ready_for_data, 1'b1);
    check("midrun_rst_done",  done, 1'b0);
    check("midrun_rst_addr",  {row, column, pixel, data_out}, '0);
    reset = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_write_enable || done) stray++;
    end
    check("midrun_no_stray", stray, 0);

    // A fresh command after the abort completes normally.
    send_cmd(8'h00, 8'h02, 8'h03, 8'h02, 8'h02, 16'hABCD);
    run(0, 0, 200);
    expect_fill_1("refill");
    check("refill_done_at", done_at, 10);
    after_done("refill");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
